// File: rtl/mul_mac_if.sv
// Operand/result handshake bundle for the mul_mac multiply-accumulate unit.
// The slave side belongs to the MAC; the master side belongs to whoever issues ops.
interface mul_mac_if #(
  parameter int unsigned n  = 8,
  parameter int unsigned aw = 16
);

  // Operand channel
  logic                 InValid;
  logic                 InReady;
  logic [1:0]           Op;
  logic signed [n-1:0]  A;
  logic signed [n-1:0]  B;

  // Result channel
  logic                 OutValid;
  logic                 OutReady;
  logic [aw-1:0]        Out;
  logic                 Overflow;

  modport master (
    output InValid,
    output Op,
    output A,
    output B,
    output OutReady,
    input  InReady,
    input  OutValid,
    input  Out,
    input  Overflow
  );

  modport slave (
    input  InValid,
    input  Op,
    input  A,
    input  B,
    input  OutReady,
    output InReady,
    output OutValid,
    output Out,
    output Overflow
  );

endinterface

// File: rtl/mul_mac.sv
// Signed multiply-accumulate unit: optional product register, then an
// accumulate stage that is also the architectural accumulator and the result
// register. One op per cycle; the whole pipe freezes while a result waits.
module mul_mac #(
  parameter int unsigned n   = 8,
  parameter int unsigned aw  = 16,
  parameter int unsigned p   = 1,
  parameter int unsigned sat = 0
) (
  input logic       Clock,
  input logic       nReset,
  mul_mac_if.slave  bus
);

  localparam int unsigned pw = 2 * n;

  localparam logic [aw-1:0] acc_max = {1'b0, {(aw-1){1'b1}}};
  localparam logic [aw-1:0] acc_min = {1'b1, {(aw-1){1'b0}}};

  typedef enum logic [1:0] {
    op_mul  = 2'b00,
    op_mac  = 2'b01,
    op_msub = 2'b10,
    op_clr  = 2'b11
  } op_e;

  // The product must fit the accumulator so that MUL can never overflow.
  if (aw < pw) begin : g_aw_check
    $error("mul_mac: aw must be at least 2*n");
  end

  // Handshake: the only stall source is an unconsumed result.
  logic stall_c;
  logic accept_c;

  assign stall_c     = bus.OutValid & ~bus.OutReady;
  assign bus.InReady = ~stall_c;
  assign accept_c    = bus.InValid & ~stall_c;

  // Full-width signed product, sign-extended to the accumulator width.
  logic signed [pw-1:0] a_ext_c;
  logic signed [pw-1:0] b_ext_c;
  logic signed [pw-1:0] prod_full_c;
  logic        [aw-1:0] prod_ext_c;

  // Operands are widened first so the product is formed at full precision.
  always_comb begin
    a_ext_c     = pw'(bus.A);
    b_ext_c     = pw'(bus.B);
    prod_full_c = a_ext_c * b_ext_c;
    prod_ext_c  = aw'(prod_full_c);
  end

  // Stage-2 inputs, either registered (p != 0) or straight from the multiplier.
  logic          s2_valid_c;
  op_e           s2_op_c;
  logic [aw-1:0] s2_prod_c;

  if (p != 0) begin : g_prod_reg
    logic          s1_valid;
    op_e           s1_op;
    logic [aw-1:0] s1_prod;

    // Product pipeline register; holds while the output is stalled.
    always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
        s1_valid <= 1'b0;
        s1_op    <= op_mul;
        s1_prod  <= '0;
      end else if (!stall_c) begin
        s1_valid <= accept_c;
        if (accept_c) begin
          s1_op   <= op_e'(bus.Op);
          s1_prod <= prod_ext_c;
        end
      end
    end

    assign s2_valid_c = s1_valid;
    assign s2_op_c    = s1_op;
    assign s2_prod_c  = s1_prod;
  end else begin : g_prod_comb
    assign s2_valid_c = accept_c;
    assign s2_op_c    = op_e'(bus.Op);
    assign s2_prod_c  = prod_ext_c;
  end

  // Accumulator, sticky overflow and result-valid state.
  logic [aw-1:0] acc_q;
  logic          ovf_q;
  logic          out_valid_q;

  logic [aw:0]   acc_wide_c;
  logic [aw:0]   prod_wide_c;
  logic [aw:0]   sum_c;
  logic          sum_ovf_c;
  logic [aw-1:0] acc_d;
  logic          ovf_d;

  // Next accumulator value; add/subtract done one bit wider to expose overflow.
  always_comb begin
    acc_wide_c  = {acc_q[aw-1], acc_q};
    prod_wide_c = {s2_prod_c[aw-1], s2_prod_c};
    sum_c       = (s2_op_c == op_msub) ? (acc_wide_c - prod_wide_c)
                                       : (acc_wide_c + prod_wide_c);
    sum_ovf_c   = sum_c[aw] ^ sum_c[aw-1];
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    case (s2_op_c)
      op_mul: begin
        acc_d = s2_prod_c;
        ovf_d = 1'b0;
      end
      op_clr: begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
      default: begin
        ovf_d = ovf_q | sum_ovf_c;
        if (sum_ovf_c && (sat != 0)) begin
          acc_d = sum_c[aw] ? acc_min : acc_max;
        end else begin
          acc_d = sum_c[aw-1:0];
        end
      end
    endcase
  end

  // Accumulate stage: a new result replaces the old one, else valid drops after transfer.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!stall_c) begin
      if (s2_valid_c) begin
        acc_q       <= acc_d;
        ovf_q       <= ovf_d;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.Out      = acc_q;
  assign bus.Overflow = ovf_q;
  assign bus.OutValid = out_valid_q;

endmodule

// File: tb/tb_mul_mac.sv
// Directed bench for mul_mac: three instances share one stimulus stream
// (p=1 wrap, p=1 saturate, p=0 wrap) and are checked against hand-computed values.
module tb_mul_mac;

  localparam logic [1:0] op_mul  = 2'b00;
  localparam logic [1:0] op_mac  = 2'b01;
  localparam logic [1:0] op_msub = 2'b10;
  localparam logic [1:0] op_clr  = 2'b11;

  logic Clock;
  logic nReset;

  logic              in_valid;
  logic [1:0]        op;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic              out_ready;

  int checks;
  int errors;

  mul_mac_if #(.n(8), .aw(16)) bus_w ();
  mul_mac_if #(.n(8), .aw(16)) bus_s ();
  mul_mac_if #(.n(8), .aw(16)) bus_c ();

  assign bus_w.InValid  = in_valid;
  assign bus_w.Op       = op;
  assign bus_w.A        = a;
  assign bus_w.B        = b;
  assign bus_w.OutReady = out_ready;

  assign bus_s.InValid  = in_valid;
  assign bus_s.Op       = op;
  assign bus_s.A        = a;
  assign bus_s.B        = b;
  assign bus_s.OutReady = out_ready;

  assign bus_c.InValid  = in_valid;
  assign bus_c.Op       = op;
  assign bus_c.A        = a;
  assign bus_c.B        = b;
  assign bus_c.OutReady = out_ready;

  mul_mac #(.n(8), .aw(16), .p(1), .sat(0)) dut_wrap (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus_w)
  );

  mul_mac #(.n(8), .aw(16), .p(1), .sat(1)) dut_sat (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus_s)
  );

  mul_mac #(.n(8), .aw(16), .p(0), .sat(0)) dut_comb (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus_c)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Record every completed output transfer of the p=1 wrap instance.
  logic [15:0] got_q[$];
  bit          mon_en;
  always @(posedge Clock) begin
    if (mon_en && bus_w.OutValid && bus_w.OutReady) got_q.push_back(bus_w.Out);
  end

  // Directed sequence tables.
  logic [1:0]        sq_op[8];
  logic signed [7:0] sq_a[8];
  logic signed [7:0] sq_b[8];
  logic [15:0]       ex_wrap[8];
  logic              ov_wrap[8];
  logic [15:0]       ex_sat[8];
  logic              ov_sat[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    op        = op_mul;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    nReset    = 1'b0;
    step();
    step();
    nReset = 1'b1;
    step();
  endtask

  task automatic set_vec(input int idx, input logic [1:0] o, input logic signed [7:0] va,
                         input logic signed [7:0] vb, input logic [15:0] ew, input logic ow,
                         input logic [15:0] es, input logic os);
    sq_op[idx]   = o;
    sq_a[idx]    = va;
    sq_b[idx]    = vb;
    ex_wrap[idx] = ew;
    ov_wrap[idx] = ow;
    ex_sat[idx]  = es;
    ov_sat[idx]  = os;
  endtask

  // Issue cnt ops back to back with OutReady held high; p=1 results trail by one cycle.
  task automatic run_seq(input int cnt, input string name);
    for (int i = 0; i <= cnt; i++) begin
      if (i < cnt) begin
        in_valid = 1'b1;
        op       = sq_op[i];
        a        = sq_a[i];
        b        = sq_b[i];
      end else begin
        in_valid = 1'b0;
      end
      check($sformatf("%s[%0d] in_ready", name, i), 32'(bus_w.InReady), 32'd1);
      step();
      if (i > 0) begin
        check($sformatf("%s[%0d] wrap valid", name, i-1), 32'(bus_w.OutValid), 32'd1);
        check($sformatf("%s[%0d] wrap out", name, i-1), 32'(bus_w.Out), 32'(ex_wrap[i-1]));
        check($sformatf("%s[%0d] wrap ovf", name, i-1), 32'(bus_w.Overflow), 32'(ov_wrap[i-1]));
        check($sformatf("%s[%0d] sat out", name, i-1), 32'(bus_s.Out), 32'(ex_sat[i-1]));
        check($sformatf("%s[%0d] sat ovf", name, i-1), 32'(bus_s.Overflow), 32'(ov_sat[i-1]));
      end
      if (i < cnt) begin
        check($sformatf("%s[%0d] p0 valid", name, i), 32'(bus_c.OutValid), 32'd1);
        check($sformatf("%s[%0d] p0 out", name, i), 32'(bus_c.Out), 32'(ex_wrap[i]));
        check($sformatf("%s[%0d] p0 ovf", name, i), 32'(bus_c.Overflow), 32'(ov_wrap[i]));
      end
    end
    step();
    check({name, " wrap valid drop"}, 32'(bus_w.OutValid), 32'd0);
    check({name, " p0 valid drop"}, 32'(bus_c.OutValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;

    // Reset state
    do_reset();
    check("rst out", 32'(bus_w.Out), 32'd0);
    check("rst out_valid", 32'(bus_w.OutValid), 32'd0);
    check("rst overflow", 32'(bus_w.Overflow), 32'd0);
    check("rst in_ready", 32'(bus_w.InReady), 32'd1);
    check("rst p0 out_valid", 32'(bus_c.OutValid), 32'd0);

    // Latency: MUL -3*5
    in_valid = 1'b1;
    op       = op_mul;
    a        = -8'sd3;
    b        = 8'sd5;
    step();
    in_valid = 1'b0;
    check("lat p1 not yet", 32'(bus_w.OutValid), 32'd0);
    check("lat p0 valid", 32'(bus_c.OutValid), 32'd1);
    check("lat p0 out", 32'(bus_c.Out), 32'h0000_FFF1);
    step();
    check("lat p1 valid", 32'(bus_w.OutValid), 32'd1);
    check("lat p1 out", 32'(bus_w.Out), 32'h0000_FFF1);
    check("lat p0 drop", 32'(bus_c.OutValid), 32'd0);
    step();
    check("lat p1 drop", 32'(bus_w.OutValid), 32'd0);

    // Chain: MUL, MAC, MSUB, CLR (operands ignored), MUL of the most negative values
    do_reset();
    set_vec(0, op_mul,  8'sd10,  8'sd10,  16'd100,   1'b0, 16'd100,   1'b0);
    set_vec(1, op_mac,  8'sd20,  8'sd5,   16'd200,   1'b0, 16'd200,   1'b0);
    set_vec(2, op_msub, 8'sd3,   8'sd4,   16'd188,   1'b0, 16'd188,   1'b0);
    set_vec(3, op_clr,  8'sd7,   8'sd9,   16'd0,     1'b0, 16'd0,     1'b0);
    set_vec(4, op_mul, -8'sd128, -8'sd128, 16'h4000, 1'b0, 16'h4000,  1'b0);
    run_seq(5, "chain");

    // Overflow: positive then negative limits, sticky flag, cleared by MUL
    do_reset();
    set_vec(0, op_mul,  8'sd127, 8'sd127, 16'd16129, 1'b0, 16'd16129, 1'b0);
    set_vec(1, op_mac,  8'sd127, 8'sd127, 16'd32258, 1'b0, 16'd32258, 1'b0);
    set_vec(2, op_mac,  8'sd127, 8'sd127, 16'hBD03,  1'b1, 16'h7FFF,  1'b1);
    set_vec(3, op_mac,  8'sd0,   8'sd0,   16'hBD03,  1'b1, 16'h7FFF,  1'b1);
    set_vec(4, op_mul,  8'sd1,   8'sd1,   16'd1,     1'b0, 16'd1,     1'b0);
    set_vec(5, op_mul, -8'sd128, 8'sd127, 16'hC080,  1'b0, 16'hC080,  1'b0);
    set_vec(6, op_msub, 8'sd127, 8'sd127, 16'h817F,  1'b0, 16'h817F,  1'b0);
    set_vec(7, op_msub, 8'sd127, 8'sd127, 16'h427E,  1'b1, 16'h8000,  1'b1);
    run_seq(8, "ovf");

    // Backpressure: 4 ops, OutReady low for 3 cycles after the first result
    do_reset();
    got_q.delete();
    mon_en   = 1'b1;
    in_valid = 1'b1;
    op = op_mul;  a = 8'sd2; b = 8'sd3;
    step();
    op = op_mac;  a = 8'sd1; b = 8'sd4;
    step();
    check("bp first valid", 32'(bus_w.OutValid), 32'd1);
    check("bp first out", 32'(bus_w.Out), 32'd6);
    out_ready = 1'b0;
    op = op_mac;  a = 8'sd2; b = 8'sd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp stall%0d in_ready", k), 32'(bus_w.InReady), 32'd0);
      check($sformatf("bp stall%0d out", k), 32'(bus_w.Out), 32'd6);
      check($sformatf("bp stall%0d valid", k), 32'(bus_w.OutValid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    op = op_msub; a = 8'sd1; b = 8'sd1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("bp drained", 32'(bus_w.OutValid), 32'd0);
    mon_en = 1'b0;
    check("bp count", 32'(got_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] exp_v;
      logic [15:0] got_v;
      case (k)
        0:       exp_v = 16'd6;
        1:       exp_v = 16'd10;
        2:       exp_v = 16'd14;
        default: exp_v = 16'd13;
      endcase
      got_v = (k < got_q.size()) ? got_q[k] : 16'hDEAD;
      check($sformatf("bp result%0d", k), 32'(got_v), 32'(exp_v));
    end

    // Reset while two ops are in flight
    do_reset();
    in_valid = 1'b1;
    op = op_mul; a = 8'sd5; b = 8'sd5;
    step();
    op = op_mac; a = 8'sd6; b = 8'sd6;
    step();
    in_valid = 1'b0;
    check("mid pre valid", 32'(bus_w.OutValid), 32'd1);
    check("mid pre out", 32'(bus_w.Out), 32'd25);
    #2;
    nReset = 1'b0;
    #1;
    check("mid rst out", 32'(bus_w.Out), 32'd0);
    check("mid rst valid", 32'(bus_w.OutValid), 32'd0);
    check("mid rst ovf", 32'(bus_w.Overflow), 32'd0);
    step();
    nReset = 1'b1;
    check("mid rel in_ready", 32'(bus_w.InReady), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mid stale%0d valid", k), 32'(bus_w.OutValid), 32'd0);
      check($sformatf("mid stale%0d out", k), 32'(bus_w.Out), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_mac.md
Name: mul_mac

Overview:
- Parametrised, optionally pipelined signed multiply-accumulate unit, built on the same multiplier primitive style as the team's mult/muladd blocks.
- Accepts one operand pair per cycle under a valid/ready handshake.
- Performs multiply, multiply-accumulate, multiply-subtract or clear against an internal accumulator.
- Sits beside the ALU in the datapath for MAC-class instructions and DSP-style kernels.

Parameters:
n, 8, operand width in bits (signed A and B).
aw, 16, accumulator/result width; must satisfy aw >= 2*n (elaboration error otherwise).
p, 1, product pipeline register: 0 = none (latency 1), 1 = registered product (latency 2).
sat, 0, 1 = saturate accumulator on signed overflow; 0 = two's-complement wrap.

Ports:
Clock  input  1  system clock, rising edge.
nReset  input  1  asynchronous, active-low reset.
InValid  input  1  operand pair and Op valid this cycle.
InReady  output  1  unit can accept; transfer occurs when InValid & InReady.
Op  input  2  00 MUL, 01 MAC, 10 MSUB, 11 CLR.
A  input  n  signed multiplicand.
B  input  n  signed multiplier.
OutValid  output  1  Out/Overflow hold a result.
OutReady  input  1  consumer accepts; transfer occurs when OutValid & OutReady.
Out  output  aw  signed accumulator value after the op.
Overflow  output  1  sticky signed-overflow flag.

Behaviour:
- Reset (async, any time, including mid-operation):
  - Out=0, OutValid=0, Overflow=0, accumulator=0.
  - All pipeline valid bits cleared; in-flight ops are discarded.
  - InReady=1 from the first cycle after release.
- Stall: stall = OutValid & ~OutReady.
  - InReady = ~stall.
  - While stalled, every pipeline register holds; no op is lost or duplicated.
- Stage 1 (p=1 only):
  - On accept, register prod = A*B as a full 2n-bit signed value, sign-extended to aw, plus Op and a valid bit.
  - For p=0 the product feeds stage 2 combinationally.
- Stage 2 (accumulate), on each non-stalled cycle with a valid stage-2 input:
  - MUL: acc = prod.
  - MAC: acc = acc + prod.
  - MSUB: acc = acc - prod.
  - CLR: acc = 0; A and B are ignored.
- Out mirrors acc; OutValid=1 for exactly one result per accepted op.
- Latency from accept to OutValid: 1+p cycles when unstalled. Throughput: 1 op/cycle.
- Back-to-back MAC/MSUB use the result of the immediately preceding op (no hazard bubble). The accumulator is the stage-2 register.
- Overflow detection (MAC/MSUB only), computed in aw+1 bits:
  - Overflow when the true sum/difference lies outside [-2^(aw-1), 2^(aw-1)-1].
  - sat=1: acc clamps to 2^(aw-1)-1 or -2^(aw-1).
  - sat=0: acc wraps modulo 2^aw.
  - The Overflow flag sets in both cases.
- Overflow is sticky: cleared by MUL, CLR or reset; updated in the same cycle as Out.
- MUL itself cannot overflow, since aw >= 2n.
- OutValid drops the cycle after the output transfer unless a new result is produced in the same cycle.
- Simultaneous output transfer and new stage-2 result: the new result replaces the old one; OutValid stays 1.

Test Plan:
- Reset: hold nReset=0, then release. Require Out=0, OutValid=0, Overflow=0, InReady=1. Repeat by asserting nReset while 2 ops are in flight: outputs clear immediately and no stale result appears afterward.
- Latency (n=8, aw=16, p=1): MUL A=-3 B=5 with OutReady=1. Require OutValid exactly 2 cycles after accept, Out=0xFFF1 (-15). With p=0, same op gives latency 1.
- Chain: back-to-back MUL 10*10, MAC 20*5, MSUB 3*4, CLR. Require Out=100, 200, 188, 0 on consecutive cycles, Overflow=0 throughout.
- Backpressure: issue 4 ops continuously while OutReady=0 for 3 cycles after the first result. Require InReady=0 during the stall, Out held stable, then all 4 results delivered in order once OutReady=1.
- Overflow, sat=1: MUL 127*127 then MAC 127*127 twice. Require Out=16129, then 32258, then 32767 with Overflow=1. A following MAC 0*0 keeps Overflow=1; a following MUL 1*1 gives Out=1, Overflow=0.
- Overflow, sat=0: same sequence as above. Require third result 0xBD03 (-17149) with Overflow=1.
